// File: rtl/sparse_pair_packer.sv
// Packs a stream of sparse bit positions into {hi,lo} words, then pads the table with
// self-cancelling {d,d} pairs. Optional macro DUMMY_RAND_EN draws d from an LFSR.
module sparse_pair_packer #(
  parameter int unsigned WORD_WIDTH      = 32,
  parameter int unsigned MEM_SPARSE_SIZE = 50,
  parameter int unsigned MAX_POS         = 17669,
  parameter int unsigned MAX_SPAN        = 63,
  parameter int unsigned DUMMY_POS       = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [15:0]           idx_in,
  input  logic                  idx_valid,
  input  logic                  idx_last,
  output logic                  idx_ready,
  output logic [9:0]            sparse_mem_addr_o,
  output logic [WORD_WIDTH-1:0] sparse_mem_write_data,
  output logic                  sparse_mem_write_en,
  output logic [9:0]            word_count,
  output logic                  busy,
  output logic                  done,
  output logic                  range_err,
  output logic                  span_err,
  output logic                  odd_err,
  output logic                  overflow_err
);

  localparam logic [9:0]  MemSize = 10'(MEM_SPARSE_SIZE);
  localparam logic [15:0] MaxPos  = 16'(MAX_POS);
  localparam logic [15:0] MaxSpan = 16'(MAX_SPAN);

  typedef enum logic [2:0] {StIdle, StGetA, StGetB, StWrite, StPad, StFinish} state_e;

  state_e      state_q, state_d;
  logic [9:0]  wp_q, wp_d;
  logic [9:0]  wc_q, wc_d;
  logic [15:0] a_q, a_d;
  logic [15:0] hi_q, hi_d;
  logic [15:0] lo_q, lo_d;
  logic        last_q, last_d;
  logic        range_q, range_d;
  logic        span_q, span_d;
  logic        odd_q, odd_d;
  logic        ovf_q, ovf_d;

  logic [15:0] pair_hi, pair_lo, span_blocks;
  logic [15:0] dummy;
  logic        pad_write;

  assign pair_hi     = (a_q < idx_in) ? a_q : idx_in;
  assign pair_lo     = (a_q < idx_in) ? idx_in : a_q;
  // Distance in 32-bit words between the two shifts; the controller has a 6-bit field for it.
  assign span_blocks = {5'd0, pair_lo[15:5]} - {5'd0, pair_hi[15:5]};
  assign pad_write   = (state_q == StPad) && (wp_q < MemSize);

`ifdef DUMMY_RAND_EN
  localparam int unsigned RedSteps = 65535 / MAX_POS;

  logic [15:0] lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 16'hACE1;
    end else if ((state_q == StIdle) && start) begin
      lfsr_q <= 16'hACE1;
    end else if (pad_write) begin
      lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
  end

  always_comb begin
    dummy = lfsr_q;
    for (int i = 0; i < int'(RedSteps); i++) begin
      if (dummy >= MaxPos) dummy = dummy - MaxPos;
    end
  end
`else
  assign dummy = 16'(DUMMY_POS);
`endif

  always_comb begin
    state_d             = state_q;
    wp_d                = wp_q;
    wc_d                = wc_q;
    a_d                 = a_q;
    hi_d                = hi_q;
    lo_d                = lo_q;
    last_d              = last_q;
    range_d             = range_q;
    span_d              = span_q;
    odd_d               = odd_q;
    ovf_d               = ovf_q;
    idx_ready           = 1'b0;
    sparse_mem_write_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          wp_d    = '0;
          wc_d    = '0;
          range_d = 1'b0;
          span_d  = 1'b0;
          odd_d   = 1'b0;
          ovf_d   = 1'b0;
          state_d = StGetA;
        end
      end
      StGetA: begin
        idx_ready = 1'b1;
        if (idx_valid) begin
          a_d = idx_in;
          if (idx_last) begin
            odd_d   = 1'b1;
            state_d = StPad;
          end else begin
            state_d = StGetB;
          end
        end
      end
      StGetB: begin
        idx_ready = 1'b1;
        if (idx_valid) begin
          hi_d   = pair_hi;
          lo_d   = pair_lo;
          last_d = idx_last;
          if ((a_q >= MaxPos) || (idx_in >= MaxPos)) range_d = 1'b1;
          if (span_blocks > MaxSpan) span_d = 1'b1;
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (wp_q < MemSize) begin
          sparse_mem_write_en = 1'b1;
          wp_d                = wp_q + 10'd1;
          wc_d                = wc_q + 10'd1;
        end else begin
          // Table full: pair is dropped but the stream is still drained.
          ovf_d = 1'b1;
        end
        state_d = last_q ? StPad : StGetA;
      end
      StPad: begin
        sparse_mem_write_en = pad_write;
        if (pad_write) wp_d = wp_q + 10'd1;
        if (!pad_write || (wp_q == MemSize - 10'd1)) state_d = StFinish;
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      wp_q    <= '0;
      wc_q    <= '0;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      last_q  <= 1'b0;
      range_q <= 1'b0;
      span_q  <= 1'b0;
      odd_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      wc_q    <= wc_d;
      a_q     <= a_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      last_q  <= last_d;
      range_q <= range_d;
      span_q  <= span_d;
      odd_q   <= odd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sparse_mem_addr_o     = wp_q;
  assign sparse_mem_write_data = (state_q == StPad) ? WORD_WIDTH'({dummy, dummy})
                                                    : WORD_WIDTH'({hi_q, lo_q});
  assign word_count            = wc_q;
  assign busy                  = (state_q != StIdle) && (state_q != StFinish);
  assign done                  = (state_q == StFinish);
  assign range_err             = range_q;
  assign span_err              = span_q;
  assign odd_err               = odd_q;
  assign overflow_err          = ovf_q;

endmodule

// File: tb/tb_sparse_pair_packer.sv
// Self-checking bench for sparse_pair_packer: directed vector table, hand sequences and
// randomized streams against a pair-list reference model of the sparse table.
module tb_sparse_pair_packer;

  localparam int Mem    = 50;
  localparam int MaxPos = 17669;

  logic        clk = 1'b0;
  logic        rst_n, start, idx_valid, idx_last;
  logic [15:0] idx_in;
  logic        idx_ready, sparse_mem_write_en, busy, done;
  logic        range_err, span_err, odd_err, overflow_err;
  logic [9:0]  sparse_mem_addr_o, word_count;
  logic [31:0] sparse_mem_write_data;

  sparse_pair_packer dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .start                 (start),
    .idx_in                (idx_in),
    .idx_valid             (idx_valid),
    .idx_last              (idx_last),
    .idx_ready             (idx_ready),
    .sparse_mem_addr_o     (sparse_mem_addr_o),
    .sparse_mem_write_data (sparse_mem_write_data),
    .sparse_mem_write_en   (sparse_mem_write_en),
    .word_count            (word_count),
    .busy                  (busy),
    .done                  (done),
    .range_err             (range_err),
    .span_err              (span_err),
    .odd_err               (odd_err),
    .overflow_err          (overflow_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write capture, sampled mid-cycle.
  logic [31:0] mem [Mem];
  int wr_count = 0, done_count = 0, bad_addr = 0, w_last_cyc = -1, done_cyc = -1;
  always @(negedge clk) begin
    if (start && !busy) begin
      for (int i = 0; i < Mem; i++) mem[i] <= 32'hDEADBEEF;
      wr_count   <= 0;
      done_count <= 0;
      bad_addr   <= 0;
      w_last_cyc <= -1;
      done_cyc   <= -1;
    end else begin
      if (sparse_mem_write_en) begin
        if (int'(sparse_mem_addr_o) < Mem) mem[sparse_mem_addr_o] <= sparse_mem_write_data;
        else bad_addr <= bad_addr + 1;
        wr_count <= wr_count + 1;
        if (int'(sparse_mem_addr_o) == Mem - 1) w_last_cyc <= cyc;
      end
      if (done) begin
        done_count <= done_count + 1;
        done_cyc   <= cyc;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: pair up the stream, then fill the rest with dummy pairs.
  logic [15:0] pos_q[$];
  logic [31:0] exp_tbl [Mem];
  int          exp_wc;
  bit          exp_rng, exp_spn, exp_odd, exp_ovf;

  task automatic model();
    int npairs, a, b, hi, lo, d;
`ifdef DUMMY_RAND_EN
    int lfsr, fb;
    lfsr = 16'hACE1;
`endif
    npairs  = pos_q.size() / 2;
    exp_odd = (pos_q.size() % 2) == 1;
    exp_rng = 0; exp_spn = 0; exp_ovf = 0; exp_wc = 0;
    for (int i = 0; i < npairs; i++) begin
      a  = int'(pos_q[2*i]);
      b  = int'(pos_q[2*i+1]);
      hi = (a < b) ? a : b;
      lo = (a < b) ? b : a;
      if (a >= MaxPos || b >= MaxPos) exp_rng = 1;
      if (lo / 32 - hi / 32 > 63) exp_spn = 1;
      if (i < Mem) begin
        exp_tbl[i] = {hi[15:0], lo[15:0]};
        exp_wc++;
      end else begin
        exp_ovf = 1;
      end
    end
    for (int k = exp_wc; k < Mem; k++) begin
`ifdef DUMMY_RAND_EN
      d    = lfsr % MaxPos;
      fb   = (lfsr ^ (lfsr >> 2) ^ (lfsr >> 3) ^ (lfsr >> 5)) & 1;
      lfsr = (lfsr >> 1) | (fb << 15);
`else
      d = 0;
`endif
      exp_tbl[k] = {d[15:0], d[15:0]};
    end
  endtask

  bit aborted = 0;

  task automatic send_pos(input logic [15:0] p, input bit last, input int gap);
    int budget;
    if (aborted) return;
    repeat (gap) begin @(posedge clk); #1; end
    idx_in = p; idx_valid = 1'b1; idx_last = last;
    budget = 0;
    forever begin
      @(negedge clk);
      if (idx_ready) break;
      budget++;
      if (budget > 200) begin
        total++; bad++;
        $display("FAIL handshake_timeout: idx_ready low for %0d cycles, expected 1", budget);
        aborted = 1;
        break;
      end
    end
    @(posedge clk); #1;
    idx_valid = 1'b0; idx_last = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int max_gap, input int start_at);
    for (int i = 0; i < pos_q.size(); i++) begin
      if (i == start_at) start = 1'b1;
      send_pos(pos_q[i], i == pos_q.size() - 1, $urandom_range(0, max_gap));
      start = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_count == 0 && n < 400) begin @(negedge clk); #1; n++; end
    chk("done_seen", done_count != 0, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_run(input string nm);
    model();
    for (int i = 0; i < Mem; i++) chk($sformatf("%s word%0d", nm, i), mem[i], exp_tbl[i]);
    chk({nm, " word_count"}, word_count, exp_wc);
    chk({nm, " range_err"}, range_err, exp_rng);
    chk({nm, " span_err"}, span_err, exp_spn);
    chk({nm, " odd_err"}, odd_err, exp_odd);
    chk({nm, " overflow_err"}, overflow_err, exp_ovf);
    chk({nm, " writes"}, wr_count, Mem);
    chk({nm, " done_pulses"}, done_count, 1);
    chk({nm, " bad_addr"}, bad_addr, 0);
    chk({nm, " busy_after"}, busy, 0);
    chk({nm, " wen_after"}, sparse_mem_write_en, 0);
    if (exp_wc < Mem) chk({nm, " done_timing"}, done_cyc, w_last_cyc + 1);
  endtask

  task automatic run_stream(input string nm, input int max_gap, input int start_at);
    pulse_start();
    feed(max_gap, start_at);
    wait_done();
    check_run(nm);
  endtask

  // Pairs whose span fits, or positions drawn slightly past the legal range.
  task automatic gen_random(input int n, input bit legal);
    int hi, lo;
    pos_q.delete();
    for (int i = 0; i < n; i++) begin
      if (legal && (i % 2 == 0)) begin
        hi = $urandom_range(0, 15000);
        lo = hi + $urandom_range(0, 2015);
        if ($urandom_range(0, 1) == 1) begin pos_q.push_back(16'(hi)); pos_q.push_back(16'(lo)); end
        else begin pos_q.push_back(16'(lo)); pos_q.push_back(16'(hi)); end
      end else if (!legal) begin
        pos_q.push_back(16'($urandom_range(0, MaxPos + 200)));
      end
    end
    while (pos_q.size() > n) void'(pos_q.pop_back());
  endtask

  task automatic outputs_zero(input string nm);
    chk({nm, " idx_ready"}, idx_ready, 0);
    chk({nm, " addr"}, sparse_mem_addr_o, 0);
    chk({nm, " wdata"}, sparse_mem_write_data, 0);
    chk({nm, " wen"}, sparse_mem_write_en, 0);
    chk({nm, " word_count"}, word_count, 0);
    chk({nm, " busy"}, busy, 0);
    chk({nm, " done"}, done, 0);
    chk({nm, " errs"}, {range_err, span_err, odd_err, overflow_err}, 0);
  endtask

  typedef struct {
    int          n;
    logic [15:0] p0, p1, p2;
    logic [31:0] w0;
    int          wc;
    bit          rng, spn, odd;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{2, 16'd100,   16'd40,    16'd0,  {16'd40, 16'd100},      1, 0, 0, 0};
    vecs[1] = '{2, 16'd5,     16'd20000, 16'd0,  {16'd5, 16'd20000},     1, 1, 1, 0};
    vecs[2] = '{2, 16'd0,     16'd4096,  16'd0,  {16'd0, 16'd4096},      1, 0, 1, 0};
    vecs[3] = '{2, 16'd0,     16'd2047,  16'd0,  {16'd0, 16'd2047},      1, 0, 0, 0};
    vecs[4] = '{2, 16'd2048,  16'd0,     16'd0,  {16'd0, 16'd2048},      1, 0, 1, 0};
    vecs[5] = '{2, 16'd17668, 16'd17669, 16'd0,  {16'd17668, 16'd17669}, 1, 1, 0, 0};
    vecs[6] = '{2, 16'd17668, 16'd17668, 16'd0,  {16'd17668, 16'd17668}, 1, 0, 0, 0};
    vecs[7] = '{3, 16'd10,    16'd20,    16'd30, {16'd10, 16'd20},       1, 0, 0, 1};
    vecs[8] = '{1, 16'd30,    16'd0,     16'd0,  32'd0,                  0, 0, 0, 1};
    vecs[9] = '{2, 16'd7,     16'd7,     16'd0,  {16'd7, 16'd7},         1, 0, 0, 0};

    rst_n = 1'b0; start = 1'b0; idx_valid = 1'b0; idx_last = 1'b0; idx_in = '0;
    #12;
    outputs_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 10; v++) begin
      pos_q.delete();
      pos_q.push_back(vecs[v].p0);
      if (vecs[v].n > 1) pos_q.push_back(vecs[v].p1);
      if (vecs[v].n > 2) pos_q.push_back(vecs[v].p2);
      run_stream($sformatf("vec%0d", v), 0, -1);
      if (vecs[v].wc > 0) chk($sformatf("vec%0d tbl_word0", v), mem[0], vecs[v].w0);
      chk($sformatf("vec%0d tbl_wc", v), word_count, vecs[v].wc);
      chk($sformatf("vec%0d tbl_errs", v), {range_err, span_err, odd_err, overflow_err},
          {vecs[v].rng, vecs[v].spn, vecs[v].odd, 1'b0});
    end

    // Exactly full table, with a stray start pulse mid-stream.
    gen_random(100, 1);
    run_stream("full100", 1, 5);
    chk("full100 wc", word_count, 50);
    chk("full100 ovf", overflow_err, 0);

    gen_random(102, 1);
    run_stream("ovf102", 0, -1);
    chk("ovf102 ovf", overflow_err, 1);
    chk("ovf102 wc", word_count, 50);

    for (int r = 0; r < 8; r++) begin
      gen_random($urandom_range(1, 105), r[0]);
      run_stream($sformatf("rand%0d", r), $urandom_range(0, 3), -1);
    end

    // Reset while wp == 10.
    gen_random(40, 1);
    pulse_start();
    for (int i = 0; i < pos_q.size(); i++) begin
      if (wr_count >= 10) break;
      send_pos(pos_q[i], i == pos_q.size() - 1, $urandom_range(0, 2));
    end
    rst_n = 1'b0;
    #1;
    outputs_zero("midreset");
    repeat (3) @(posedge clk);
    #1;
    chk("midreset done_pulses", done_count, 0);
    chk("midreset writes", wr_count, 10);
    model();
    for (int i = 0; i < 10; i++) chk($sformatf("midreset word%0d", i), mem[i], exp_tbl[i]);
    rst_n = 1'b1;
    @(posedge clk); #1;
    gen_random(37, 0);
    run_stream("restart", 2, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sparse_pair_packer.md
Name: sparse_pair_packer

Overview:
- Upstream stage of the sparse polynomial multiply controller; fills the sparse memory that the controller reads one 32-bit word per run.
- Accepts a stream of sparse bit positions and packs them in pairs into words: high position in [31:16], low position in [15:0].
- Pads the rest of the table with self-cancelling dummy pairs {d,d}; over GF(2) the two shifts XOR to zero. This keeps the number of controller runs constant, whatever the real weight.
- Flags input that the controller cannot process.

Parameters:
- WORD_WIDTH, 32, sparse memory word width (packed pair = 2x16 bits).
- MEM_SPARSE_SIZE, 50, number of words in the sparse table, all of which are always written.
- MAX_POS, 17669, exclusive upper bound on a legal position.
- MAX_SPAN, 63, maximum allowed value of (low>>5)-(high>>5); this fits the controller's 6-bit word-offset field.
- DUMMY_POS, 0, position used in dummy pairs.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begin filling the table (ignored while busy)
- idx_in  in  16  sparse bit position
- idx_valid  in  1  idx_in valid
- idx_last  in  1  marks the final position of the stream; qualified by idx_valid
- idx_ready  out  1  position accepted when idx_valid && idx_ready
- sparse_mem_addr_o  out  10  write address
- sparse_mem_write_data  out  32  packed pair
- sparse_mem_write_en  out  1  write strobe
- word_count  out  10  number of real (non-dummy) words written
- busy  out  1  table fill in progress
- done  out  1  one-cycle pulse when the table is complete
- range_err  out  1  sticky; a position >= MAX_POS was received
- span_err  out  1  sticky; a pair exceeded MAX_SPAN
- odd_err  out  1  sticky; the stream ended with an unpaired position
- overflow_err  out  1  sticky; more than 2*MEM_SPARSE_SIZE positions were received

Behaviour:
- Reset: every output is 0; state IDLE; internal word pointer wp is 0.
- States: IDLE, GET_A, GET_B, WRITE, PAD, FINISH.
- IDLE:
  - On start: busy=1; wp, word_count and all err flags are cleared; go to GET_A.
  - start is ignored in every other state.
- GET_A: idx_ready=1. On handshake, latch A.
  - idx_last=1: odd_err=1, A is dropped, go to PAD.
  - Otherwise: go to GET_B.
- GET_B: idx_ready=1. On handshake, latch B; hi=min(A,B), lo=max(A,B); go to WRITE, remembering idx_last.
- WRITE (one cycle): idx_ready=0; write_en=1, addr=wp, data={hi,lo}.
  - If wp==MEM_SPARSE_SIZE: no write; overflow_err=1.
  - Otherwise: wp++, word_count++.
  - Next state: PAD if the latched last flag is set, else GET_A.
- Overflow: once wp reaches MEM_SPARSE_SIZE, later pairs are still accepted and discarded, and overflow_err is raised.
- Checks, evaluated at the B handshake:
  - range_err if A or B >= MAX_POS.
  - span_err if (lo>>5)-(hi>>5) > MAX_SPAN.
  - Flagged pairs are still written.
- Latency: write_en asserts on the cycle after the second handshake; the maximum accept rate is 2 positions per 3 cycles.
- PAD: while wp < MEM_SPARSE_SIZE, write {d,d} at addr=wp, one word per cycle, wp++. word_count does not change. When wp==MEM_SPARSE_SIZE, go to FINISH.
- FINISH: done=1 for one cycle; busy=0; return to IDLE. All outputs other than done keep their values until the next start.
- sparse_mem_write_en is 0 in every state other than WRITE and PAD.
- An A and B handshake in consecutive cycles is legal. idx_valid with idx_ready=0 is held by the source; no data is lost.
- Asynchronous reset mid-fill: immediate return to IDLE with all outputs 0. The partial table is left as written, and no done pulse is produced.

Optional Feature:
- Macro DUMMY_RAND_EN.
- Defined: d comes from a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1, loaded on start), reduced into [0, MAX_POS) by conditionally subtracting MAX_POS. The LFSR advances once per dummy word. Each dummy word is still {d,d}, so it cancels.
- Undefined: d=DUMMY_POS for every dummy word; no LFSR is instantiated.

Test Plan:
- Positions 100, 40, last → word0 = {16'd40, 16'd100}; words 1..49 = {0,0}; word_count=1; done pulses one cycle after the address-49 write; no err flags.
- 100 positions (50 pairs, last on the 100th) → 50 real writes, no PAD writes, word_count=50, done, no errors.
- 102 positions → first 50 words written, pair 51 discarded, overflow_err=1, done still pulses.
- Positions 5, 20000, last → range_err=1; positions 0, 4096 → (4096>>5)-0 = 128 > 63, span_err=1; both words written anyway.
- 3 positions with last on the third → 1 real word, odd_err=1, 49 dummy words.
- idx_valid toggling with gaps, and reset asserted while wp=10 → no lost or duplicated positions; after reset, all outputs are 0 and start restarts cleanly from wp=0.
